// File: rtl/mult_share_ctrl_if.sv
// Bus bundle between mult_share_ctrl, its requesters and the single shared multiplier.
// Latency: none; this file holds wires only.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
interface mult_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  // requester side
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  // response side
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_y;
  logic                 rsp_err;
  // multiplier side
  logic                 mul_start;
  logic [15:0]          mul_ain;
  logic [15:0]          mul_bin;
  logic                 mul_done;
  logic [31:0]          mul_yout;
  // status
  logic                 busy;

  // controller view
  modport master (
    input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_yout,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_err,
    output mul_start, mul_ain, mul_bin, busy
  );

  // requesters + multiplier view
  modport slave (
    output req_valid, req_a, req_b, rsp_ready, mul_done, mul_yout,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_err,
    input  mul_start, mul_ain, mul_bin, busy
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin share of one 16-bit shift-add multiplier between NREQ requesters; product tagged with requester id.
// Latency: grant in cycle 0, mul_start from cycle 1, response one cycle after mul_done (cycle 19 with a 17-cycle multiplier).
// Backpressure: rsp_valid holds with mul_start low until rsp_ready; no grants while busy. Optional watchdog: MULT_SHARE_TIMEOUT_EN.
module mult_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  mult_share_ctrl_if.master bus
);

  // Parameter sanity: the id field must be able to name every requester.
  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT < 1) begin : g_bad_param
    $error("mult_share_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // arbitration
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    w_gnt_idx;
  logic [IDW-1:0]    w_ptr_nxt;
  logic [IDW:0]      w_idx;
  logic [IDW:0]      w_ptr_inc;
  logic              w_any;
  logic [NREQ-1:0]   w_req_ready;

  // operand / result holding registers
  logic [15:0]       r_ain;
  logic [15:0]       r_bin;
  logic [15:0]       w_sel_a;
  logic [15:0]       w_sel_b;
  logic [IDW-1:0]    r_id;
  logic [31:0]       r_y;

  // FSM event strobes
  logic              w_grant_fire;
  logic              w_done_fire;
  logic              w_start;

`ifdef MULT_SHARE_TIMEOUT_EN
  // r_cnt counts RUN cycles already spent; it never passes TIMEOUT-1 because RUN is left there.
  localparam int CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNTW-1:0]   r_cnt;
  logic              r_err;
  logic              w_expire_fire;
`endif

  // Round-robin search: first valid requester at or above r_ptr, wrapping modulo NREQ.
  // Walking downward means the last hit written is the closest one to r_ptr.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(j);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (bus.req_valid[w_idx[IDW-1:0]]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_idx[IDW-1:0];
      end
    end
  end

  // Winner's operands and the pointer value that follows it.
  always_comb begin
    w_sel_a   = bus.req_a[{w_gnt_idx, 4'b0000} +: 16];
    w_sel_b   = bus.req_b[{w_gnt_idx, 4'b0000} +: 16];
    w_ptr_inc = {1'b0, w_gnt_idx} + (IDW+1)'(1);
    w_ptr_nxt = (w_ptr_inc >= (IDW+1)'(NREQ)) ? '0 : w_ptr_inc[IDW-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state strobes; mul_done only matters while in RUN.
  always_comb begin
    w_state_nxt   = r_state;
    w_req_ready   = '0;
    w_start       = 1'b0;
    w_grant_fire  = 1'b0;
    w_done_fire   = 1'b0;
`ifdef MULT_SHARE_TIMEOUT_EN
    w_expire_fire = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_req_ready  = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt_idx;
          w_grant_fire = 1'b1;
          w_state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        w_start = 1'b1;
        if (bus.mul_done) begin
          // a real completion beats a watchdog expiry in the same cycle
          w_done_fire = 1'b1;
          w_state_nxt = ST_RESP;
        end
`ifdef MULT_SHARE_TIMEOUT_EN
        else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
          w_expire_fire = 1'b1;
          w_state_nxt   = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping: operands held stable for the multiplier, id and pointer advance on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_ain <= '0;
      r_bin <= '0;
    end else if (w_grant_fire) begin
      r_ptr <= w_ptr_nxt;
      r_id  <= w_gnt_idx;
      r_ain <= w_sel_a;
      r_bin <= w_sel_b;
    end
  end

`ifdef MULT_SHARE_TIMEOUT_EN
  // Result capture: product on done, zero plus error flag on watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y   <= '0;
      r_err <= 1'b0;
    end else if (w_done_fire) begin
      r_y   <= bus.mul_yout;
      r_err <= 1'b0;
    end else if (w_expire_fire) begin
      r_y   <= '0;
      r_err <= 1'b1;
    end
  end

  // Watchdog counter: cleared on the way into RUN, counts each RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_grant_fire) begin
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign bus.rsp_err = r_err;
`else
  // Result capture: product passes through untouched; without the watchdog RUN can only end on done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
    end else if (w_done_fire) begin
      r_y <= bus.mul_yout;
    end
  end

  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = w_req_ready;
  assign bus.mul_start = w_start;
  assign bus.mul_ain   = r_ain;
  assign bus.mul_bin   = r_bin;
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_y     = r_y;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: vector table, directed corner sequences, random traffic vs a transaction model.
// Latency: the bench multiplier raises mul_done mul_lat cycles after mul_start rises (17 by default).
// Backpressure: rsp_ready is driven by the bench, held low in the directed cases and random in the random phase.
module tb_mult_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) mif ();

  mult_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.master)
  );

  int n_vec = 0;
  int n_err = 0;

  // Bench multiplier: done is a level, raised mul_lat cycles after start rose, held until start drops.
  int mul_lat  = 17;
  bit mul_hang = 1'b0;
  int mcnt     = 0;
  always_ff @(posedge clk) mcnt <= mif.mul_start ? mcnt + 1 : 0;
  assign mif.mul_done = mif.mul_start && !mul_hang && (mcnt >= mul_lat);
  assign mif.mul_yout = mif.mul_done ? ({16'h0, mif.mul_ain} * {16'h0, mif.mul_bin}) : 32'hDEAD_BEEF;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  ready;
    logic [1:0]  id;
    logic [31:0] y;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [15:0] a, input logic [15:0] b);
    mif.req_a[16*k +: 16] = a;
    mif.req_b[16*k +: 16] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mif.req_valid = '0;
    mif.rsp_ready = 1'b0;
    to_pos();
    to_pos();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_req_ready"}, mif.req_ready, 0);
    check({tag, "_rsp_valid"}, mif.rsp_valid, 0);
    check({tag, "_rsp_id"},    mif.rsp_id, 0);
    check({tag, "_rsp_y"},     mif.rsp_y, 0);
    check({tag, "_rsp_err"},   mif.rsp_err, 0);
    check({tag, "_mul_start"}, mif.mul_start, 0);
    check({tag, "_mul_ain"},   mif.mul_ain, 0);
    check({tag, "_mul_bin"},   mif.mul_bin, 0);
    check({tag, "_busy"},      mif.busy, 0);
  endtask

  // Entered at the negedge of the grant cycle; leaves at the negedge of the first rsp_valid cycle.
  task automatic op_to_rsp(input string tag, input logic [1:0] exp_id, input logic [31:0] exp_y,
                           input bit exp_err, input int exp_lat, input logic [15:0] ea, input logic [15:0] eb);
    int cyc;
    int budget;
    to_pos();
    mif.req_valid = '0;
    @(negedge clk);
    cyc = 1;
    check({tag, "_start"}, mif.mul_start, 1);
    check({tag, "_ain"}, mif.mul_ain, ea);
    check({tag, "_bin"}, mif.mul_bin, eb);
    budget = 200;
    while (!mif.rsp_valid && budget > 0) begin
      to_pos();
      @(negedge clk);
      cyc++;
      budget--;
    end
    check({tag, "_rsp_seen"}, mif.rsp_valid, 1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_id"}, mif.rsp_id, exp_id);
    check({tag, "_y"}, mif.rsp_y, exp_y);
    check({tag, "_err"}, mif.rsp_err, exp_err);
  endtask

  task automatic handshake();
    mif.rsp_ready = 1'b1;
    to_pos();
    mif.rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ng, nr, seen;
    int gc[5];
    logic [31:0] yb2b[4];
    int ptr, gcyc, glat, g;
    bit mbusy, found;
    logic [1:0] eid;
    logic [31:0] ey;
    logic [3:0] rv;
    logic [15:0] la[NREQ];
    logic [15:0] lb[NREQ];

    tbl[0] = '{4'b0001, 16'h0003, 16'h0005, 4'b0001, 2'd0, 32'h0000_000F};
    tbl[1] = '{4'b0001, 16'hFFFF, 16'hFFFF, 4'b0001, 2'd0, 32'hFFFE_0001};
    tbl[2] = '{4'b1001, 16'h0100, 16'h0100, 4'b1000, 2'd3, 32'h0001_0000};
    tbl[3] = '{4'b1010, 16'h1234, 16'h0002, 4'b0010, 2'd1, 32'h0000_2468};
    tbl[4] = '{4'b0011, 16'h0000, 16'hABCD, 4'b0001, 2'd0, 32'h0000_0000};
    tbl[5] = '{4'b0100, 16'h8000, 16'h0002, 4'b0100, 2'd2, 32'h0001_0000};
    tbl[6] = '{4'b1111, 16'h00FF, 16'h0101, 4'b1000, 2'd3, 32'h0000_FFFF};
    tbl[7] = '{4'b1110, 16'h7FFF, 16'h0003, 4'b0010, 2'd1, 32'h0001_7FFD};

    mif.req_a = '0;
    mif.req_b = '0;
    do_reset();
    check_reset_state("rst0");

    // Vector table: grant pointer carries over from one entry to the next.
    to_pos();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NREQ; k++) set_lane(k, tbl[i].a ^ 16'h5A5A, tbl[i].b ^ 16'hA5A5);
      set_lane(int'(tbl[i].id), tbl[i].a, tbl[i].b);
      mif.req_valid = tbl[i].mask;
      @(negedge clk);
      check("tbl_ready", mif.req_ready, tbl[i].ready);
      op_to_rsp("tbl", tbl[i].id, tbl[i].y, 1'b0, 19, tbl[i].a, tbl[i].b);
      handshake();
    end

    // Reset after activity must clear the held operands and result.
    do_reset();
    check_reset_state("rst1");

    // Back-to-back with all four valid: order 0,1,2,3,0 every 20 cycles.
    do_reset();
    set_lane(0, 16'h0003, 16'h0005); yb2b[0] = 32'h0000_000F;
    set_lane(1, 16'h0010, 16'h0010); yb2b[1] = 32'h0000_0100;
    set_lane(2, 16'h1234, 16'h0001); yb2b[2] = 32'h0000_1234;
    set_lane(3, 16'hFFFF, 16'hFFFF); yb2b[3] = 32'hFFFE_0001;
    mif.req_valid = 4'hF;
    mif.rsp_ready = 1'b1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 150 && ng < 5; c++) begin
      @(negedge clk);
      if (mif.req_ready != '0) begin
        check("b2b_grant", mif.req_ready, 64'd1 << (ng % 4));
        gc[ng] = c;
        ng++;
      end
      if (mif.rsp_valid && nr < 4) begin
        check("b2b_id", mif.rsp_id, nr);
        check("b2b_y", mif.rsp_y, yb2b[nr]);
        nr++;
      end
      to_pos();
    end
    check("b2b_grants", ng, 5);
    check("b2b_rsps", nr, 4);
    if (ng == 5) begin
      for (int i = 0; i < 4; i++) check("b2b_spacing", gc[i+1] - gc[i], 20);
    end

    // Backpressure: response held stable, no start, no grant while a request waits.
    do_reset();
    set_lane(0, 16'h0007, 16'h0009);
    set_lane(1, 16'h0002, 16'h0003);
    mif.req_valid = 4'b0001;
    @(negedge clk);
    check("bp_ready", mif.req_ready, 4'b0001);
    op_to_rsp("bp", 2'd0, 32'h0000_003F, 1'b0, 19, 16'h0007, 16'h0009);
    mif.req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      to_pos();
      @(negedge clk);
      check("bp_hold_valid", mif.rsp_valid, 1);
      check("bp_hold_y", mif.rsp_y, 32'h0000_003F);
      check("bp_hold_id", mif.rsp_id, 0);
      check("bp_hold_start", mif.mul_start, 0);
      check("bp_hold_ready", mif.req_ready, 0);
    end
    handshake();
    @(negedge clk);
    check("bp_next_grant", mif.req_ready, 4'b0010);
    op_to_rsp("bp2", 2'd1, 32'h0000_0006, 1'b0, 19, 16'h0002, 16'h0003);
    handshake();

    // Reset in RUN cycle 8: operation dropped, pointer back to 0.
    do_reset();
    set_lane(0, 16'h0011, 16'h0011);
    set_lane(2, 16'h0022, 16'h0022);
    mif.req_valid = 4'b0100;
    @(negedge clk);
    check("rr_ready", mif.req_ready, 4'b0100);
    to_pos();
    mif.req_valid = '0;
    repeat (7) to_pos();
    rst = 1'b1;
    to_pos();
    rst = 1'b0;
    @(negedge clk);
    check("rr_start", mif.mul_start, 0);
    check("rr_busy", mif.busy, 0);
    check("rr_valid", mif.rsp_valid, 0);
    seen = 0;
    repeat (30) begin
      to_pos();
      @(negedge clk);
      if (mif.rsp_valid) seen++;
    end
    check("rr_no_rsp", seen, 0);
    to_pos();
    mif.req_valid = 4'hF;
    @(negedge clk);
    check("rr_ptr0", mif.req_ready, 4'b0001);
    op_to_rsp("rr", 2'd0, 32'h0000_0121, 1'b0, 19, 16'h0011, 16'h0011);
    handshake();

    // Requester 2 withdraws before its turn; requester 3 gets the grant.
    do_reset();
    set_lane(1, 16'h0004, 16'h0004);
    set_lane(2, 16'h2222, 16'h0002);
    set_lane(3, 16'h0300, 16'h0003);
    mif.req_valid = 4'b0010;
    @(negedge clk);
    check("wd_ready1", mif.req_ready, 4'b0010);
    op_to_rsp("wd1", 2'd1, 32'h0000_0010, 1'b0, 19, 16'h0004, 16'h0004);
    to_pos();
    mif.req_valid = 4'b1100;
    to_pos();
    to_pos();
    mif.req_valid = 4'b1000;
    @(negedge clk);
    handshake();
    @(negedge clk);
    check("wd_grant3", mif.req_ready, 4'b1000);
    op_to_rsp("wd2", 2'd3, 32'h0000_0900, 1'b0, 19, 16'h0300, 16'h0003);
    handshake();

    // Multiplier never completes.
    do_reset();
    mul_hang = 1'b1;
    set_lane(0, 16'h0005, 16'h0005);
    mif.req_valid = 4'b0001;
    @(negedge clk);
    check("hang_ready", mif.req_ready, 4'b0001);
`ifdef MULT_SHARE_TIMEOUT_EN
    op_to_rsp("tmo", 2'd0, 32'h0, 1'b1, 32, 16'h0005, 16'h0005);
    handshake();
    mif.req_valid = 4'hF;
    @(negedge clk);
    check("tmo_ptr_adv", mif.req_ready, 4'b0010);
`else
    to_pos();
    mif.req_valid = '0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (mif.rsp_valid) seen++;
      to_pos();
    end
    @(negedge clk);
    check("hang_busy", mif.busy, 1);
    check("hang_start", mif.mul_start, 1);
    check("hang_no_rsp", seen, 0);
`endif
    mul_hang = 1'b0;

    // Random traffic against a transaction-level model.
    do_reset();
    ptr = 0;
    mbusy = 1'b0;
    gcyc = 0;
    glat = 0;
    eid = '0;
    ey = '0;
    for (int c = 0; c < 3000; c++) begin
      rv = 4'($urandom_range(0, 15));
      mif.req_valid = rv;
      for (int k = 0; k < NREQ; k++) begin
        la[k] = 16'($urandom);
        lb[k] = 16'($urandom);
        set_lane(k, la[k], lb[k]);
      end
      mif.rsp_ready = 1'($urandom_range(0, 1));
      if (!mbusy) mul_lat = $urandom_range(1, 20);
      @(negedge clk);
      if (!mbusy) begin
        found = 1'b0;
        g = 0;
        for (int j = 0; j < NREQ; j++) begin
          if (!found && rv[(ptr + j) % NREQ]) begin
            found = 1'b1;
            g = (ptr + j) % NREQ;
          end
        end
        check("rnd_grant", mif.req_ready, found ? (64'd1 << g) : 64'd0);
        if (found) begin
          mbusy = 1'b1;
          gcyc = c;
          glat = mul_lat;
          eid = 2'(g);
          ey = la[g] * lb[g];
          ptr = (g + 1) % NREQ;
        end
      end else begin
        check("rnd_no_grant", mif.req_ready, 0);
        check("rnd_rsp_valid", mif.rsp_valid, (c - gcyc) >= glat + 2);
        if (mif.rsp_valid && mif.rsp_ready) begin
          check("rnd_id", mif.rsp_id, eid);
          check("rnd_y", mif.rsp_y, ey);
          check("rnd_err", mif.rsp_err, 0);
          mbusy = 1'b0;
        end
      end
      to_pos();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
